// File: rtl/noc_pkg.sv
// Shared flit-link definitions: default packet geometry, derived flit counts
// and the receiver state encoding.
package noc_pkg;

  localparam int DEF_FLIT_SIZE    = 4;
  localparam int DEF_PACKET_SIZE  = 32;
  localparam int DEF_ADDRESS_SIZE = 16;

  localparam int DEF_ADDRESS_FLIT_NUMBER = DEF_ADDRESS_SIZE / DEF_FLIT_SIZE;
  localparam int DEF_FLIT_NUMBER         = DEF_PACKET_SIZE / DEF_FLIT_SIZE;
  localparam int DEF_PAYLOAD_FLIT_NUMBER = DEF_FLIT_NUMBER - DEF_ADDRESS_FLIT_NUMBER;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    RECV_ADDR    = 2'd1,
    RECV_PAYLOAD = 2'd2
  } rx_state_t;

endpackage

// File: rtl/flit_shift_register.sv
// Serial-in, parallel-out register; each enabled cycle shifts one flit in at the LSBs.
module flit_shift_register #(
  parameter int width     = 32,
  parameter int flit_size = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic [flit_size-1:0] flit_in,
  output logic [width-1:0]     data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {data[width-flit_size-1:0], flit_in};
    end
  end

endmodule

// File: rtl/flit_receiver.sv
// Receiving end of the serial flit link: reassembles address and payload flits
// into a parallel packet, exposes the address early and drives backpressure.
module flit_receiver
  import noc_pkg::*;
#(
  parameter int flit_size    = DEF_FLIT_SIZE,
  parameter int packet_size  = DEF_PACKET_SIZE,
  parameter int address_size = DEF_ADDRESS_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [flit_size-1:0]    flit_in,
  input  logic                    flit_valid,
  output logic                    stall,
  output logic [address_size-1:0] dest_address,
  output logic                    address_valid,
  output logic [packet_size-1:0]  packet_out,
  output logic                    packet_valid,
  input  logic                    packet_ready,
  output logic                    overflow_error
);

  localparam int address_flit_number = address_size / flit_size;
  localparam int flit_number         = packet_size / flit_size;
  localparam int payload_flit_number = flit_number - address_flit_number;
  localparam int cnt_w               = $clog2(flit_number + 1);

  localparam logic [cnt_w-1:0] ADDR_LAST = cnt_w'(address_flit_number);
  localparam logic [cnt_w-1:0] PKT_LAST  = cnt_w'(flit_number);

  rx_state_t              state, state_next;
  logic [cnt_w-1:0]       cnt, cnt_next, cnt_inc;
  logic                   shift_en, addr_done, pkt_done;
  logic [packet_size-1:0] shift_q, shift_next;

  flit_shift_register #(
    .width     (packet_size),
    .flit_size (flit_size)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .flit_in  (flit_in),
    .data     (shift_q)
  );

  // Contents the shift register will hold once the current flit is in; the
  // address and packet are captured from here in the same cycle as the flit.
  assign shift_next = {shift_q[packet_size-flit_size-1:0], flit_in};
  assign cnt_inc    = cnt + cnt_w'(1);
  assign stall      = (state != IDLE) | packet_valid;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_en   = 1'b0;
    addr_done  = 1'b0;
    pkt_done   = 1'b0;
    case (state)
      IDLE: begin
        if (flit_valid && !packet_valid) begin
          shift_en = 1'b1;
          cnt_next = cnt_w'(1);
          if (address_flit_number == 1) begin
            addr_done  = 1'b1;
            state_next = RECV_PAYLOAD;
          end else begin
            state_next = RECV_ADDR;
          end
        end
      end
      RECV_ADDR: begin
        if (flit_valid) begin
          shift_en = 1'b1;
          cnt_next = cnt_inc;
          if (cnt_inc == ADDR_LAST) begin
            addr_done  = 1'b1;
            state_next = RECV_PAYLOAD;
          end
        end
      end
      RECV_PAYLOAD: begin
        if (flit_valid) begin
          shift_en = 1'b1;
          cnt_next = cnt_inc;
          if (cnt_inc == PKT_LAST) begin
            pkt_done   = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      dest_address   <= '0;
      address_valid  <= 1'b0;
      packet_out     <= '0;
      packet_valid   <= 1'b0;
      overflow_error <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      address_valid <= addr_done;
      if (addr_done) begin
        dest_address <= shift_next[address_size-1:0];
      end
      if (pkt_done) begin
        packet_out   <= shift_next;
        packet_valid <= 1'b1;
      end else if (packet_valid && packet_ready) begin
        packet_valid <= 1'b0;
      end
      // A flit offered while a packet is still held has nowhere to go.
      if (state == IDLE && flit_valid && packet_valid) begin
        overflow_error <= 1'b1;
      end
    end
  end

endmodule
